// File: rtl/pwr_level_detector.sv
`default_nettype none
// ============================================================================
// Module   : pwr_level_detector
// Brief    : Windowed min/max/mean power statistics with valid/ready report
//            output, plus a hysteretic carrier-detect comparator.
// Revision : 1.0
// ============================================================================
module pwr_level_detector #(
  parameter int WIDTH        = 32,
  parameter int WIN_MAX_LOG2 = 16,
  parameter int DET_CNT      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwr_en,
  input  logic [WIDTH-1:0] pwr_in,
  input  logic [4:0]       win_log2,
  input  logic [WIDTH-1:0] thr_on,
  input  logic [WIDTH-1:0] thr_off,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [WIDTH-1:0] rpt_max,
  output logic [WIDTH-1:0] rpt_min,
  output logic [WIDTH-1:0] rpt_mean,
  output logic             rpt_ovf,
  output logic             det,
  output logic             det_edge
);

  localparam int         c_ACC_W   = WIDTH + WIN_MAX_LOG2;
  localparam int         c_CNT_W   = WIN_MAX_LOG2 + 1;
  localparam int         c_DET_W   = $clog2(DET_CNT + 1);
  localparam logic [4:0] c_WL_MAX  = 5'(WIN_MAX_LOG2);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_DET_W-1:0] c_DET_ONE = c_DET_W'(1);
  localparam logic [c_DET_W-1:0] c_DET_LAST = c_DET_W'(DET_CNT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t               r_state;
  logic                 r_pwr_en;
  logic [WIDTH-1:0]     r_pwr;
  logic [4:0]           r_wl;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_ACC_W-1:0]   r_acc;
  logic [WIDTH-1:0]     r_max;
  logic [WIDTH-1:0]     r_min;
  logic                 r_fin_vld;
  logic [WIDTH-1:0]     r_fin_max;
  logic [WIDTH-1:0]     r_fin_min;
  logic [WIDTH-1:0]     r_fin_mean;
  logic                 r_det_int;
  logic [c_DET_W-1:0]   r_det_cnt;

  logic [4:0]           w_wl_clamp;
  logic                 w_win_last;
  logic [c_ACC_W-1:0]   w_acc_sum;
  logic [c_ACC_W-1:0]   w_mean_full;
  logic [WIDTH-1:0]     w_max;
  logic [WIDTH-1:0]     w_min;
  logic                 w_det_qual;

  assign w_wl_clamp  = (win_log2 > c_WL_MAX) ? c_WL_MAX : win_log2;
  assign w_win_last  = (r_cnt == ((c_CNT_ONE << r_wl) - c_CNT_ONE));
  assign w_acc_sum   = r_acc + {{WIN_MAX_LOG2{1'b0}}, r_pwr};
  assign w_mean_full = w_acc_sum >> r_wl;
  assign w_max       = (r_pwr > r_max) ? r_pwr : r_max;
  assign w_min       = (r_pwr < r_min) ? r_pwr : r_min;
  assign w_det_qual  = r_det_int ? (r_pwr < thr_off) : (r_pwr >= thr_on);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwr_en <= 1'b0;
      r_pwr    <= '0;
    end else begin
      r_pwr_en <= pwr_en;
      r_pwr    <= pwr_in;
    end
  end

  // Window statistics; the final sample of a window restarts the next one
  // in the same cycle so back-to-back samples never see a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wl       <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_max      <= '0;
      r_min      <= '1;
      r_fin_vld  <= 1'b0;
      r_fin_max  <= '0;
      r_fin_min  <= '0;
      r_fin_mean <= '0;
    end else begin
      r_fin_vld <= 1'b0;
      if (!en) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ACCUM;
            r_wl    <= w_wl_clamp;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_max   <= '0;
            r_min   <= '1;
          end
          ST_ACCUM: begin
            if (r_pwr_en) begin
              if (w_win_last) begin
                r_fin_vld  <= 1'b1;
                r_fin_max  <= w_max;
                r_fin_min  <= w_min;
                r_fin_mean <= w_mean_full[WIDTH-1:0];
                r_wl       <= w_wl_clamp;
                r_cnt      <= '0;
                r_acc      <= '0;
                r_max      <= '0;
                r_min      <= '1;
              end else begin
                r_acc <= w_acc_sum;
                r_max <= w_max;
                r_min <= w_min;
                r_cnt <= r_cnt + c_CNT_ONE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_valid <= 1'b0;
      rpt_ovf   <= 1'b0;
      rpt_max   <= '0;
      rpt_min   <= '0;
      rpt_mean  <= '0;
    end else if (r_fin_vld) begin
      rpt_valid <= 1'b1;
      rpt_ovf   <= rpt_valid && !rpt_ready;
      rpt_max   <= r_fin_max;
      rpt_min   <= r_fin_min;
      rpt_mean  <= r_fin_mean;
    end else if (rpt_valid && rpt_ready) begin
      rpt_valid <= 1'b0;
      rpt_ovf   <= 1'b0;
    end
  end

  // r_det_int switches thresholds immediately; det is its one-cycle-late copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_det_int <= 1'b0;
      r_det_cnt <= '0;
      det       <= 1'b0;
      det_edge  <= 1'b0;
    end else begin
      det      <= r_det_int;
      det_edge <= r_det_int ^ det;
      if (!en) begin
        r_det_cnt <= '0;
      end else if (r_pwr_en) begin
        if (w_det_qual) begin
          if (r_det_cnt == c_DET_LAST) begin
            r_det_int <= ~r_det_int;
            r_det_cnt <= '0;
          end else begin
            r_det_cnt <= r_det_cnt + c_DET_ONE;
          end
        end else begin
          r_det_cnt <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwr_level_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwr_level_detector
// Brief    : Randomized and directed bench for pwr_level_detector against an
//            event-scheduled reference model.
// Revision : 1.0
// ============================================================================
module tb_pwr_level_detector;

  localparam int WIDTH = 32;
  localparam int WL    = 16;
  localparam int DC    = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             pwr_en;
  logic [WIDTH-1:0] pwr_in;
  logic [4:0]       win_log2;
  logic [WIDTH-1:0] thr_on;
  logic [WIDTH-1:0] thr_off;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [WIDTH-1:0] rpt_max;
  logic [WIDTH-1:0] rpt_min;
  logic [WIDTH-1:0] rpt_mean;
  logic             rpt_ovf;
  logic             det;
  logic             det_edge;

  pwr_level_detector #(.WIDTH(WIDTH), .WIN_MAX_LOG2(WL), .DET_CNT(DC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pwr_en(pwr_en), .pwr_in(pwr_in),
    .win_log2(win_log2), .thr_on(thr_on), .thr_off(thr_off),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_max(rpt_max),
    .rpt_min(rpt_min), .rpt_mean(rpt_mean), .rpt_ovf(rpt_ovf),
    .det(det), .det_edge(det_edge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] mean;
  } rpt_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  rpt_t        sched_rpt[int];
  bit          sched_det[int];
  logic [WIDTH-1:0] win_q[$];
  int          m_wl;
  bit          m_det_state, m_vld, m_ovf, m_det, m_edge;
  int          m_dcnt;
  rpt_t        m_rpt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int clamp_wl(input int w);
    return (w > WL) ? WL : w;
  endfunction

  task automatic model_reset();
    sched_rpt.delete();
    sched_det.delete();
    win_q.delete();
    m_det_state = 0; m_vld = 0; m_ovf = 0; m_det = 0; m_edge = 0; m_dcnt = 0;
    m_rpt = '{mx: '0, mn: '0, mean: '0};
  endtask

  // A sample captured at edge k produces its report / detect change at k+2.
  task automatic model_sample(input logic [WIDTH-1:0] s, input int k);
    bit qual;
    if (win_q.size() == 0) m_wl = clamp_wl(int'(win_log2));
    win_q.push_back(s);
    if (win_q.size() == (1 << m_wl)) begin
      logic [63:0] sum;
      rpt_t r;
      sum = '0;
      r.mx = '0;
      r.mn = '1;
      foreach (win_q[i]) begin
        sum += 64'(win_q[i]);
        if (win_q[i] > r.mx) r.mx = win_q[i];
        if (win_q[i] < r.mn) r.mn = win_q[i];
      end
      sum = sum >> m_wl;
      r.mean = sum[WIDTH-1:0];
      sched_rpt[k + 2] = r;
      win_q.delete();
    end
    qual = m_det_state ? (s < thr_off) : (s >= thr_on);
    if (qual) begin
      m_dcnt++;
      if (m_dcnt == DC) begin
        m_det_state = !m_det_state;
        m_dcnt = 0;
        sched_det[k + 2] = 1'b1;
      end
    end else begin
      m_dcnt = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit rdy);
    if (sched_rpt.exists(k)) begin
      m_ovf = m_vld && !rdy;
      m_vld = 1'b1;
      m_rpt = sched_rpt[k];
      sched_rpt.delete(k);
    end else if (m_vld && rdy) begin
      m_vld = 1'b0;
      m_ovf = 1'b0;
    end
    m_edge = sched_det.exists(k);
    if (m_edge) begin
      m_det = !m_det;
      sched_det.delete(k);
    end
  endtask

  task automatic compare_all();
    check("rpt_valid", 64'(rpt_valid), 64'(m_vld));
    check("rpt_ovf", 64'(rpt_ovf), 64'(m_ovf));
    check("det", 64'(det), 64'(m_det));
    check("det_edge", 64'(det_edge), 64'(m_edge));
    if (m_vld) begin
      check("rpt_max", 64'(rpt_max), 64'(m_rpt.mx));
      check("rpt_min", 64'(rpt_min), 64'(m_rpt.mn));
      check("rpt_mean", 64'(rpt_mean), 64'(m_rpt.mean));
    end
  endtask

  task automatic step();
    bit rdy;
    rdy = rpt_ready;
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(cyc, rdy);
    #1;
    compare_all();
  endtask

  task automatic drv(input bit v, input logic [WIDTH-1:0] d, input bit rdy);
    pwr_en    = v;
    pwr_in    = d;
    rpt_ready = rdy;
    if (v && en && rst_n) model_sample(d, cyc + 1);
    step();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drv(1'b0, '0, rdy);
  endtask

  task automatic reconfig(input int w, input int on, input int off);
    idle(2, 1'b1);
    en = 1'b0;
    win_q.delete();
    m_dcnt = 0;
    idle(2, 1'b1);
    win_log2 = 5'(w);
    thr_on   = WIDTH'(on);
    thr_off  = WIDTH'(off);
    en = 1'b1;
    idle(2, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pwr_en = 1'b0; pwr_in = '0; rpt_ready = 1'b0;
    win_log2 = 5'd2; thr_on = 100; thr_off = 50;
    model_reset();
    #1;
    compare_all();
    idle(3, 1'b0);
    rst_n = 1'b1;
    idle(2, 1'b0);
    en = 1'b1;
    idle(3, 1'b1);

    // W=2, back-to-back 10..40 with consumer always ready
    drv(1, 10, 1); drv(1, 20, 1); drv(1, 30, 1); drv(1, 40, 1);
    idle(4, 1'b1);

    // W=0 with gaps between samples
    reconfig(0, 100, 50);
    drv(1, 7, 1); idle(2, 1'b1); drv(1, 9, 1); idle(4, 1'b1);

    // W=1, no consumer: overwrite; then ready pulsed in the load cycle
    reconfig(1, 100, 50);
    drv(1, 1, 0); drv(1, 3, 0); drv(1, 5, 0); drv(1, 7, 0);
    idle(4, 1'b0);
    drv(1, 1, 0); drv(1, 3, 0); drv(1, 5, 0); drv(1, 7, 0);
    drv(0, 0, 0); drv(0, 0, 1); drv(0, 0, 0);
    idle(3, 1'b1);

    // Hysteretic detect sequence
    reconfig(2, 100, 50);
    for (int i = 0; i < 3; i++) drv(1, 120, 1);
    drv(1, 90, 1);
    for (int i = 0; i < 4; i++) drv(1, 120, 1);
    for (int i = 0; i < 10; i++) drv(1, 80, 1);
    for (int i = 0; i < 4; i++) drv(1, 40, 1);
    idle(4, 1'b1);

    // Randomized phases
    for (int p = 0; p < 6; p++) begin
      reconfig(int'($urandom_range(0, 4)), int'($urandom_range(80, 150)),
               int'($urandom_range(30, 90)));
      for (int i = 0; i < 300; i++) begin
        logic [WIDTH-1:0] d;
        d = ($urandom_range(0, 15) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 200));
        drv(bit'($urandom_range(0, 3) != 0), d, bit'($urandom_range(0, 1)));
      end
      idle(4, 1'b1);
    end

    // Reset in the middle of a window while det is asserted
    reconfig(2, 100, 50);
    for (int i = 0; i < 5; i++) drv(1, 200, 1);
    idle(3, 1'b1);
    check("det_before_reset", 64'(det), 64'(1));
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    idle(3, 1'b1);
    rst_n = 1'b1;
    idle(2, 1'b1);
    drv(1, 4, 1); drv(1, 4, 1); drv(1, 4, 1); drv(1, 4, 1);
    drv(0, 0, 1); drv(0, 0, 1);
    check("mean_after_reset", 64'(rpt_mean), 64'(4));
    idle(3, 1'b1);

    // Clamped window of full-scale samples
    reconfig(20, 100, 50);
    for (int i = 0; i < 65536; i++) drv(1, 32'hFFFF_FFFF, 1);
    drv(0, 0, 1); drv(0, 0, 1);
    check("big_mean", 64'(rpt_mean), 64'(32'hFFFF_FFFF));
    check("big_valid", 64'(rpt_valid), 64'(1));
    idle(3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwr_level_detector.md
# pwr_level_detector

Consumer of the power meter output: takes the scaled power word produced every clock by the I/Q power meter, collects min/max/mean statistics over programmable power-of-two windows, and hands each window report to the control side over a valid/ready handshake. In parallel it runs a hysteretic carrier-detect comparator on the same power stream, used by the modem's acquisition logic.

## Interface
- `WIDTH`, 32, power word width (matches power meter output)
- `WIN_MAX_LOG2`, 16, largest window exponent; accumulator is WIDTH+WIN_MAX_LOG2 bits
- `DET_CNT`, 4, consecutive qualifying samples needed to change detect state (≥1)

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `en` in 1: block enable
- `pwr_en` in 1: sample strobe; `pwr_in` is valid when high
- `pwr_in` in WIDTH: power word from the power meter
- `win_log2` in 5: window = 2^win_log2 samples; values above WIN_MAX_LOG2 clamp to WIN_MAX_LOG2
- `thr_on` in WIDTH: detect-assert threshold, compared with ≥
- `thr_off` in WIDTH: detect-release threshold, compared with <
- `rpt_valid` out 1: report available
- `rpt_ready` in 1: consumer accepts report
- `rpt_max`, `rpt_min`, `rpt_mean` out WIDTH each: window statistics
- `rpt_ovf` out 1: a previous unaccepted report was overwritten
- `det` out 1: carrier detect level
- `det_edge` out 1: one-cycle pulse on any `det` change

## Operation
- Input stage registers `pwr_in`/`pwr_en` (1 edge).
- FSM: IDLE → ACCUM when `en`=1; any state → IDLE when `en`=0 (partial window discarded; pending report and `det` retained).
- On window start: latch clamped `win_log2`; count=0, acc=0, max=0, min=all-ones. Config changes mid-window take effect at the next window.
- ACCUM, per registered sample: acc+=sample, max/min updated, count++. At sample 2^W, update report registers with max, min, mean=(acc+sample)>>W (truncating, exactly WIDTH bits, no overflow possible); restart the window on the next sample without a gap.
- Report register: on load, `rpt_valid`=1. `rpt_ovf`=1 if the load overwrote a report still valid and not accepted in that cycle; otherwise 0.
- Handshake: transfer when `rpt_valid`&&`rpt_ready`; `rpt_valid` clears next edge unless a new report loads in the same cycle (then stays 1, `rpt_ovf`=0). Data is stable while `rpt_valid`=1 and `rpt_ready`=0, except on overwrite.
- Detect: while `det`=0, counter increments on samples ≥`thr_on`, else clears; reaching DET_CNT sets `det`, clears the counter. While `det`=1, the same rule applies with samples <`thr_off`. Only `pwr_en` samples count; gaps do not clear the counter. Detect runs only when `en`=1; with `en`=0, the counter is held cleared.

## Timing
- Reset (async assert, sync-safe release): all outputs 0, FSM IDLE, counters 0.
- Report latency: `rpt_valid` rises 2 edges after the edge sampling the window's last `pwr_en`=1 sample.
- Detect latency: `det` changes 2 edges after the edge sampling the DET_CNT-th qualifying sample; `det_edge` is high for that same single cycle.
- W=0: every sample produces a report; max=min=mean=sample.
- Throughput: one sample per clock sustained, no back-pressure on `pwr_in`.
- Reset mid-window: partial statistics are lost; the first window after release starts with the first enabled sample.

## Test plan
- W=2, `rpt_ready`=1, samples 10,20,30,40 back-to-back → one report max=40, min=10, mean=25, ovf=0; `rpt_valid` high 1 cycle, 2 edges after 40 is sampled.
- W=0, samples 7,9 with `pwr_en` gaps → two reports, each max=min=mean=sample.
- W=1, `rpt_ready`=0, samples 1,3,5,7 → second report max=7, min=5, mean=6, ovf=1; repeat with `rpt_ready` pulsed in the load cycle → ovf=0, `rpt_valid` stays 1.
- `thr_on`=100, `thr_off`=50, DET_CNT=4: 120×3, 90, 120×4 → `det` 0→1 once, with a single `det_edge`; 80×10 → `det` stays 1; 40×4 → `det`=0 with `det_edge`.
- `win_log2`=20 (clamped to 16), 65536 samples of 0xFFFFFFFF → mean=0xFFFFFFFF, max=min=0xFFFFFFFF.
- Assert `rst_n`=0 mid-window with `det`=1 → all outputs 0 immediately; after release, W=2 with samples 4,4,4,4 → mean=4, with no leftover contribution from before reset.
